register_stream_port: RTL

- Debug/bootstrap client that sits on the register bank's selector/data interface and drives it from the other side.
- Dump: reads registers 0..NUM_REGS-1 in order through the rx selector and streams each byte out over a valid/ready channel.
- Load: accepts NUM_REGS bytes from a valid/ready input channel and writes them into registers 0..NUM_REGS-1 in order through the bank write port.
- Sits between the host link (UART framer) and the register bank; CPU control is stalled while busy is high.

---
 rtl/register_stream_port_pkg.sv | 25 ++
 rtl/register_stream_port_if.sv | 41 ++++
 rtl/register_stream_port.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/register_stream_port_pkg.sv
// Shared definitions for the register stream port: sequencer states, default
// geometry, and the host opcodes the framer uses to request a dump or a load.
package register_stream_port_pkg;

    localparam int NUM_REGS_DEFAULT   = 8;
    localparam int SEL_WIDTH_DEFAULT  = 3;
    localparam int DATA_WIDTH_DEFAULT = 8;

    localparam logic [7:0] OPCODE_DUMP = 8'h44;
    localparam logic [7:0] OPCODE_LOAD = 8'h4C;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DUMP_READ  = 3'd1,
        DUMP_SEND  = 3'd2,
        LOAD_WAIT  = 3'd3,
        LOAD_WRITE = 3'd4,
        DONE       = 3'd5
    } state_e;

    function automatic logic is_busy_state(input state_e s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/register_stream_port_if.sv
// Bank selector/data port plus the outgoing and incoming byte streams.
// master = the stream port, slave = the bank/host side.
interface register_stream_port_if
    import register_stream_port_pkg::*;
#(
    parameter int SEL_WIDTH  = SEL_WIDTH_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
);

    logic [SEL_WIDTH-1:0]  bank_rx_selector;
    logic                  bank_write_en;
    logic [DATA_WIDTH-1:0] bank_data;
    logic [DATA_WIDTH-1:0] bank_rx_data;

    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;

    modport master (
        output bank_rx_selector, bank_write_en, bank_data,
        input  bank_rx_data,
        output tx_data, tx_valid,
        input  tx_ready,
        input  rx_data, rx_valid,
        output rx_ready
    );

    modport slave (
        input  bank_rx_selector, bank_write_en, bank_data,
        output bank_rx_data,
        input  tx_data, tx_valid,
        output tx_ready,
        output rx_data, rx_valid,
        input  rx_ready
    );

endinterface

// File: rtl/register_stream_port.sv
// Debug/bootstrap client for the register bank: dumps every register onto a
// valid/ready byte stream, or loads every register from one, in index order.
module register_stream_port
    import register_stream_port_pkg::*;
#(
    parameter int NUM_REGS   = NUM_REGS_DEFAULT,
    parameter int SEL_WIDTH  = SEL_WIDTH_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start_dump,
    input  logic start_load,
    output logic busy,
    output logic done,
    register_stream_port_if.master bus
);

    localparam logic [SEL_WIDTH-1:0]  IDX_ZERO  = {SEL_WIDTH{1'b0}};
    localparam logic [SEL_WIDTH-1:0]  IDX_ONE   = SEL_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0]  LAST_IDX  = SEL_WIDTH'(NUM_REGS - 1);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    state_e                state_r;
    state_e                state_next_s;
    logic [SEL_WIDTH-1:0]  idx_r;
    logic [SEL_WIDTH-1:0]  idx_next_s;
    logic                  is_last_s;

    logic [DATA_WIDTH-1:0] tx_data_r;
    logic                  tx_valid_r;
    logic                  tx_valid_next_s;
    logic                  tx_load_s;
    logic [DATA_WIDTH-1:0] bank_data_r;
    logic                  bank_load_s;

    logic                  busy_r;
    logic                  done_r;
    logic                  rx_ready_r;
    logic                  bank_write_en_r;

    assign is_last_s = (idx_r == LAST_IDX);

    // Next-state, index and datapath-load decode for the transfer sequencer.
    always_comb begin
        state_next_s    = state_r;
        idx_next_s      = idx_r;
        tx_valid_next_s = tx_valid_r;
        tx_load_s       = 1'b0;
        bank_load_s     = 1'b0;
        case (state_r)
            IDLE: begin
                // A simultaneous request resolves to the dump.
                if (start_dump) begin
                    state_next_s = DUMP_READ;
                    idx_next_s   = IDX_ZERO;
                end else if (start_load) begin
                    state_next_s = LOAD_WAIT;
                    idx_next_s   = IDX_ZERO;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DUMP_READ: begin
                tx_load_s       = 1'b1;
                tx_valid_next_s = 1'b1;
                state_next_s    = DUMP_SEND;
            end
            DUMP_SEND: begin
                if (tx_valid_r && bus.tx_ready) begin
                    tx_valid_next_s = 1'b0;
                    if (is_last_s) begin
                        state_next_s = DONE;
                    end else begin
                        idx_next_s   = idx_r + IDX_ONE;
                        state_next_s = DUMP_READ;
                    end
                end else begin
                    state_next_s = DUMP_SEND;
                end
            end
            LOAD_WAIT: begin
                if (bus.rx_valid && rx_ready_r) begin
                    bank_load_s  = 1'b1;
                    state_next_s = LOAD_WRITE;
                end else begin
                    state_next_s = LOAD_WAIT;
                end
            end
            LOAD_WRITE: begin
                if (is_last_s) begin
                    state_next_s = DONE;
                end else begin
                    idx_next_s   = idx_r + IDX_ONE;
                    state_next_s = LOAD_WAIT;
                end
            end
            DONE: begin
                state_next_s = IDLE;
                idx_next_s   = IDX_ZERO;
            end
            default: begin
                state_next_s    = IDLE;
                idx_next_s      = IDX_ZERO;
                tx_valid_next_s = 1'b0;
            end
        endcase
    end

    // Sequencer state and register index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= IDX_ZERO;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
        end
    end

    // Stream/bank data registers and status flags; the state-decoded flags are
    // registered from the next state so they line up with the state they mark.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_r       <= DATA_ZERO;
            tx_valid_r      <= 1'b0;
            bank_data_r     <= DATA_ZERO;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            rx_ready_r      <= 1'b0;
            bank_write_en_r <= 1'b0;
        end else begin
            tx_valid_r <= tx_valid_next_s;
            if (tx_load_s) begin
                tx_data_r <= bus.bank_rx_data;
            end
            if (bank_load_s) begin
                bank_data_r <= bus.rx_data;
            end
            busy_r          <= is_busy_state(state_next_s);
            done_r          <= (state_next_s == DONE);
            rx_ready_r      <= (state_next_s == LOAD_WAIT);
            bank_write_en_r <= (state_next_s == LOAD_WRITE);
        end
    end

    assign busy                 = busy_r;
    assign done                 = done_r;
    assign bus.bank_rx_selector = idx_r;
    assign bus.bank_write_en    = bank_write_en_r;
    assign bus.bank_data        = bank_data_r;
    assign bus.tx_data          = tx_data_r;
    assign bus.tx_valid         = tx_valid_r;
    assign bus.rx_ready         = rx_ready_r;

endmodule
